axil_gpio_ctrl: RTL and testbench
=================================

# axil_gpio_ctrl

AXI4-Lite slave GPIO controller on the peripheral port of `soc_top_picorv32_axi`; it produces `gpio_out`/`gpio_oe` and consumes `gpio_in`. It decodes CPU register accesses into output-data, direction and input-sample registers. An optional rising-edge interrupt unit is included. The interconnect strips the peripheral base, so the block decodes only address bits [4:2].

## Interface
- `ADDR_WIDTH`, 32: AXI address width; only bits [4:2] are decoded.
- `GPIO_WIDTH`, 16: number of pins, 1..32.
- `aclk`  in  1: clock; all logic is on the rising edge.
- `areset`  in  1: asynchronous, active-high reset. The clock is `aclk`; reset is asynchronous and active-high.
- `s_awaddr`/`s_awvalid`/`s_awready`: AXI4-Lite write address channel, width ADDR_WIDTH; `s_awready` is out.
- `s_wdata`/`s_wstrb`/`s_wvalid`/`s_wready`: write data channel, 32/4/1/1 bits; `s_wready` is out.
- `s_bresp`/`s_bvalid` out 2/1, `s_bready` in 1: write response channel.
- `s_araddr`/`s_arvalid` in, `s_arready` out: read address channel.
- `s_rdata`/`s_rresp`/`s_rvalid` out 32/2/1, `s_rready` in 1: read data channel.
- `gpio_in`  in  GPIO_WIDTH: asynchronous pin inputs.
- `gpio_out`  out  GPIO_WIDTH: output data register.
- `gpio_oe`  out  GPIO_WIDTH: direction register; 1 means driven.
- `irq`  out  1: registered level interrupt.

## Operation
- Register map (byte offsets):
  - 0x00 DATA_OUT: RW.
  - 0x04 DIR: RW.
  - 0x08 DATA_IN: RO, synchronized value.
  - 0x0C IRQ_EN: RW.
  - 0x10 IRQ_STATUS: RW1C.
- Offsets 0x14–0x1C are unmapped:
  - Reads return 0 with SLVERR (2'b10).
  - Writes are dropped and answer SLVERR.
- Writes honor `s_wstrb` per byte. Bits at or above GPIO_WIDTH read 0 and ignore writes.
- Writes to DATA_IN are ignored and answer OKAY.
- Write path:
  - AW and W are accepted independently, in any order, into holding registers.
  - `s_awready` = !aw_held && !s_bvalid.
  - `s_wready` = !w_held && !s_bvalid.
- Write commit happens on the first edge where both address and data are available (held or handshaking that edge):
  - The register is updated.
  - `s_bvalid` rises and the holds clear.
  - `s_bvalid` holds until `s_bready`.
- Read path:
  - `s_arready` = !s_rvalid.
  - On the AR handshake edge, `s_rdata`/`s_rresp` are captured and `s_rvalid` rises.
  - Outputs hold stable until `s_rready`.
- Input path: `gpio_in` passes through a 2-flop synchronizer (sync2); DATA_IN = sync2.
- Edge detection: a rising edge is sync2 & ~sync3. It sets the matching IRQ_STATUS bit.
- `irq` is registered: |(IRQ_STATUS & IRQ_EN).
- Simultaneous events:
  - A W1C and an edge on the same bit in the same cycle: the set wins.
  - A read of IRQ_STATUS in the same cycle as an edge returns the pre-edge value.
  - A read and a write in the same cycle are independent; a read sees the value before the write commit.

## Timing
- Reset values are 0 for:
  - all registers and holds;
  - `s_awready`, `s_wready`, `s_arready`, `s_bvalid`, `s_rvalid`, `s_bresp`, `s_rresp`, `s_rdata`;
  - `gpio_out`, `gpio_oe`, `irq`.
- `s_*ready` may rise one cycle after `areset` deasserts.
- Write latency: with AW and W together at edge N, `s_bvalid`, `gpio_out` and `gpio_oe` update at edge N.
- Read latency: AR at edge N gives `s_rvalid` at edge N.
- Throughput: one write per 2 cycles and one read per 2 cycles when ready is held high.
- Pin-change-to-DATA_IN latency is 2 edges; pin-to-`irq` latency is 4 edges.
- Reset mid-transaction drops the pending holds and responses; no response is produced afterward.

## Configuration
- `AXIL_GPIO_IRQ_EN` defined: the IRQ_EN/IRQ_STATUS registers, the edge detector and `irq` are built.
- `AXIL_GPIO_IRQ_EN` undefined:
  - Offsets 0x0C and 0x10 read 0 with OKAY, and writes are ignored with OKAY.
  - `irq` is tied 0.
  - No sync3 stage is built.

## Structure
- Package `axil_gpio_pkg`:
  - register offset constants;
  - AXI response codes (OKAY = 2'b00, SLVERR = 2'b10);
  - offset-decode index type.
- Sub-module `gpio_in_sync`, parameterized by width, contains:
  - the 2-flop synchronizer;
  - the optional sync3 stage and rise-edge vector output.

## Test plan
- Write 0x00 = 0x0055 with AW and W in the same cycle, then read 0x00 → `gpio_out` = 0x0055 at the commit edge; BRESP OKAY; RDATA 0x00000055.
- W arrives 3 cycles before AW, writing 0x04 = 0xFFFF with `s_wstrb` = 4'b0001 → `gpio_oe` = 0x00FF; `s_bvalid` only after AW; one response.
- Drive `gpio_in` = 0x00AA, wait 3 cycles, read 0x08 → 0x000000AA OKAY. Read 0x14 → 0x0 SLVERR.
- IRQ_EN = 0x0001, then raise `gpio_in[0]` → `irq` = 1 within 4 edges and IRQ_STATUS = 0x1. Write 0x10 = 0x1 → `irq` = 0 next edge.
- Hold `s_bready` = 0 and `s_rready` = 0 for 5 cycles → BVALID/RVALID and the data stay stable; `s_awready` = 0 throughout.
- Assert `areset` while a write is half-accepted → all outputs go to 0 immediately; no BVALID follows.

Source files
------------

// File: rtl/axil_gpio_pkg.sv
// Shared constants and types for the AXI4-Lite GPIO controller: register
// offsets, AXI response codes, offset-decode index type and a strobe helper.
package axil_gpio_pkg;

  typedef enum logic [2:0] {
    IDX_DATA_OUT   = 3'd0,
    IDX_DIR        = 3'd1,
    IDX_DATA_IN    = 3'd2,
    IDX_IRQ_EN     = 3'd3,
    IDX_IRQ_STATUS = 3'd4,
    IDX_RSVD5      = 3'd5,
    IDX_RSVD6      = 3'd6,
    IDX_RSVD7      = 3'd7
  } reg_idx_e;

  localparam logic [4:0] OFF_DATA_OUT   = {IDX_DATA_OUT,   2'b00};
  localparam logic [4:0] OFF_DIR        = {IDX_DIR,        2'b00};
  localparam logic [4:0] OFF_DATA_IN    = {IDX_DATA_IN,    2'b00};
  localparam logic [4:0] OFF_IRQ_EN     = {IDX_IRQ_EN,     2'b00};
  localparam logic [4:0] OFF_IRQ_STATUS = {IDX_IRQ_STATUS, 2'b00};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axil_gpio_ctrl_if.sv
// AXI4-Lite slave bus bundle for axil_gpio_ctrl; master side is the interconnect.
interface axil_gpio_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/gpio_in_sync.sv
// Two-flop pin synchronizer; with AXIL_GPIO_IRQ_EN a third stage provides a
// rising-edge vector, otherwise the edge output is tied low.
module gpio_in_sync #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_o = sync2_q;

`ifdef AXIL_GPIO_IRQ_EN
  logic [WIDTH-1:0] sync3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync3_q <= '0;
    else       sync3_q <= sync2_q;
  end

  assign rise_o = sync2_q & ~sync3_q;
`else
  assign rise_o = '0;
`endif

endmodule

// File: rtl/axil_gpio_ctrl.sv
// AXI4-Lite GPIO controller: DATA_OUT/DIR/DATA_IN registers, plus IRQ_EN,
// IRQ_STATUS (RW1C) and a registered irq when AXIL_GPIO_IRQ_EN is defined.
module axil_gpio_ctrl
  import axil_gpio_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned GPIO_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  axil_gpio_ctrl_if.slave       s_axil,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);
  logic                  live_q;
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [GPIO_WIDTH-1:0] dout_q, dout_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;

  logic [GPIO_WIDTH-1:0] din_sync;
  logic [GPIO_WIDTH-1:0] din_rise;

  logic                  aw_fire, w_fire, ar_fire, commit;
  reg_idx_e              wr_idx, rd_idx;
  logic [31:0]           wr_data, wr_mask, rd_val;
  logic [1:0]            rd_resp;
  logic [GPIO_WIDTH-1:0] wr_bits, wr_keep;

`ifdef AXIL_GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [GPIO_WIDTH-1:0] irq_st_q, irq_st_d;
  logic [GPIO_WIDTH-1:0] w1c;
  logic                  irq_q;
`endif

  gpio_in_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk_i  (aclk),
    .rst_i  (areset),
    .async_i(gpio_in),
    .sync_o (din_sync),
    .rise_o (din_rise)
  );

  assign s_axil.s_awready = live_q && !aw_held_q && !bvalid_q;
  assign s_axil.s_wready  = live_q && !w_held_q  && !bvalid_q;
  assign s_axil.s_arready = live_q && !rvalid_q;
  assign s_axil.s_bvalid  = bvalid_q;
  assign s_axil.s_bresp   = bresp_q;
  assign s_axil.s_rvalid  = rvalid_q;
  assign s_axil.s_rdata   = rdata_q;
  assign s_axil.s_rresp   = rresp_q;

  assign aw_fire = s_axil.s_awvalid && s_axil.s_awready;
  assign w_fire  = s_axil.s_wvalid  && s_axil.s_wready;
  assign ar_fire = s_axil.s_arvalid && s_axil.s_arready;
  // Commit as soon as both halves are present, whether held or arriving now.
  assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire);

  assign wr_idx  = reg_idx_e'(aw_held_q ? awaddr_q[4:2] : s_axil.s_awaddr[4:2]);
  assign wr_data = w_held_q ? wdata_q : s_axil.s_wdata;
  assign wr_mask = strb_to_mask(w_held_q ? wstrb_q : s_axil.s_wstrb);
  assign wr_bits = wr_data[GPIO_WIDTH-1:0] & wr_mask[GPIO_WIDTH-1:0];
  assign wr_keep = ~wr_mask[GPIO_WIDTH-1:0];
  assign rd_idx  = reg_idx_e'(s_axil.s_araddr[4:2]);

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    dout_d    = dout_q;
    dir_d     = dir_q;
`ifdef AXIL_GPIO_IRQ_EN
    irq_en_d  = irq_en_q;
    w1c       = '0;
`endif

    if (bvalid_q && s_axil.s_bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (wr_idx)
        IDX_DATA_OUT: dout_d = (dout_q & wr_keep) | wr_bits;
        IDX_DIR:      dir_d  = (dir_q  & wr_keep) | wr_bits;
        IDX_DATA_IN:  ;
`ifdef AXIL_GPIO_IRQ_EN
        IDX_IRQ_EN:     irq_en_d = (irq_en_q & wr_keep) | wr_bits;
        IDX_IRQ_STATUS: w1c      = wr_bits;
`else
        IDX_IRQ_EN:     ;
        IDX_IRQ_STATUS: ;
`endif
        default:      bresp_d = RESP_SLVERR;
      endcase
    end else begin
      if (aw_fire) begin
        aw_held_d = 1'b1;
        awaddr_d  = s_axil.s_awaddr;
      end
      if (w_fire) begin
        w_held_d = 1'b1;
        wdata_d  = s_axil.s_wdata;
        wstrb_d  = s_axil.s_wstrb;
      end
    end

`ifdef AXIL_GPIO_IRQ_EN
    // A new edge outranks a same-cycle clear of that bit.
    irq_st_d = (irq_st_q & ~w1c) | din_rise;
`endif
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      IDX_DATA_OUT: rd_val[GPIO_WIDTH-1:0] = dout_q;
      IDX_DIR:      rd_val[GPIO_WIDTH-1:0] = dir_q;
      IDX_DATA_IN:  rd_val[GPIO_WIDTH-1:0] = din_sync;
`ifdef AXIL_GPIO_IRQ_EN
      IDX_IRQ_EN:     rd_val[GPIO_WIDTH-1:0] = irq_en_q;
      IDX_IRQ_STATUS: rd_val[GPIO_WIDTH-1:0] = irq_st_q;
`else
      IDX_IRQ_EN:     ;
      IDX_IRQ_STATUS: ;
`endif
      default:      rd_resp = RESP_SLVERR;
    endcase

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil.s_rready) rvalid_d = 1'b0;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_resp;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      dout_q    <= '0;
      dir_q     <= '0;
    end else begin
      live_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      dout_q    <= dout_d;
      dir_q     <= dir_d;
    end
  end

`ifdef AXIL_GPIO_IRQ_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq_en_q <= '0;
      irq_st_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_st_q <= irq_st_d;
      irq_q    <= |(irq_st_q & irq_en_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;

  logic unused_bits;
  assign unused_bits = ^{awaddr_q, s_axil.s_araddr, wr_data, wr_mask, din_rise};

endmodule

// File: tb/tb_axil_gpio_ctrl.sv
// Self-checking bench for axil_gpio_ctrl: directed steps plus randomized
// register traffic compared against a byte-lane register model.
module tb_axil_gpio_ctrl;
  import axil_gpio_pkg::*;

  localparam int unsigned GW = 16;
  localparam logic [31:0] WMASK = 32'((64'd1 << GW) - 64'd1);

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [GW-1:0] gpio_in = '0;
  logic [GW-1:0] gpio_out;
  logic [GW-1:0] gpio_oe;
  logic          irq;

  axil_gpio_ctrl_if #(.ADDR_WIDTH(32)) bus();

  axil_gpio_ctrl #(.ADDR_WIDTH(32), .GPIO_WIDTH(GW)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_axil  (bus),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 aclk = ~aclk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] m_out = '0;
  logic [31:0] m_dir = '0;
  logic [31:0] snap_out, snap_oe;
  logic        snap_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    end
    return v & WMASK;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [2:0] idx;
    idx = addr[4:2];
    if (idx == 3'd0)      m_out = merge(m_out, data, strb);
    else if (idx == 3'd1) m_dir = merge(m_dir, data, strb);
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] addr);
    logic [2:0] idx;
    idx = addr[4:2];
    return (idx >= 3'd5) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [2:0] idx;
    idx = addr[4:2];
    case (idx)
      3'd0:    return m_out;
      3'd1:    return m_dir;
      3'd2:    return 32'(gpio_in);
      default: return 32'd0;
    endcase
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic ok);
    logic aw_hs, w_hs;
    ok = 1'b0;
    resp = 2'b11;
    bus.s_awaddr = addr;  bus.s_awvalid = 1'b1;
    bus.s_wdata  = data;  bus.s_wstrb = strb; bus.s_wvalid = 1'b1;
    bus.s_bready = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      tick();
      if (aw_hs) bus.s_awvalid = 1'b0;
      if (w_hs)  bus.s_wvalid  = 1'b0;
      if (bus.s_bvalid) begin
        ok = 1'b1;
        resp = bus.s_bresp;
        snap_out = 32'(gpio_out);
        snap_oe  = 32'(gpio_oe);
        snap_irq = irq;
      end
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    tick();
    bus.s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output logic ok);
    logic ar_hs;
    ok = 1'b0;
    data = 'x;
    resp = 2'b11;
    bus.s_araddr = addr; bus.s_arvalid = 1'b1; bus.s_rready = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      ar_hs = bus.s_arvalid && bus.s_arready;
      tick();
      if (ar_hs) bus.s_arvalid = 1'b0;
      if (bus.s_rvalid) begin
        ok = 1'b1;
        data = bus.s_rdata;
        resp = bus.s_rresp;
      end
    end
    bus.s_arvalid = 1'b0;
    tick();
    bus.s_rready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    logic [1:0] resp;
    logic       ok;
    axi_write(addr, data, strb, resp, ok);
    chk({tag, "_bto"}, 32'(ok), 32'd1);
    chk({tag, "_bresp"}, 32'(resp), 32'(model_resp(addr)));
    model_write(addr, data, strb);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                         input logic [1:0] exp_resp);
    logic [31:0] data;
    logic [1:0]  resp;
    logic        ok;
    axi_read(addr, data, resp, ok);
    chk({tag, "_rto"}, 32'(ok), 32'd1);
    chk({tag, "_rdata"}, data, exp);
    chk({tag, "_rresp"}, 32'(resp), 32'(exp_resp));
  endtask

  initial begin
    logic [31:0] old_out, addr, data;
    logic [2:0]  idx;
    logic [3:0]  strb;

    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata  = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'd0);
    chk("rst_valid", 32'({bus.s_bvalid, bus.s_rvalid}), 32'd0);
    chk("rst_resp",  32'({bus.s_bresp, bus.s_rresp}), 32'd0);
    chk("rst_rdata", bus.s_rdata, 32'd0);
    chk("rst_pins",  32'({gpio_out, gpio_oe, irq}), 32'd0);
    areset = 1'b0;
    repeat (2) tick();
    chk("post_rst_ready", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'h7);

    // AW+W together, then read back
    do_write("w_dout", 32'(OFF_DATA_OUT), 32'h0000_0055, 4'hF);
    chk("dout_at_commit", snap_out, 32'h55);
    do_read("r_dout", 32'(OFF_DATA_OUT), 32'h0000_0055, 2'b00);

    // W three cycles ahead of AW, single byte strobe
    bus.s_wdata = 32'h0000_FFFF; bus.s_wstrb = 4'b0001; bus.s_wvalid = 1'b1; bus.s_bready = 1'b1;
    chk("w_first_wready", 32'(bus.s_wready), 32'd1);
    tick();
    bus.s_wvalid = 1'b0;
    repeat (2) tick();
    chk("w_first_nob", 32'(bus.s_bvalid), 32'd0);
    chk("w_first_held", 32'(bus.s_wready), 32'd0);
    bus.s_awaddr = 32'(OFF_DIR); bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    model_write(32'(OFF_DIR), 32'h0000_FFFF, 4'b0001);
    chk("w_first_b", 32'(bus.s_bvalid), 32'd1);
    chk("w_first_bresp", 32'(bus.s_bresp), 32'd0);
    chk("w_first_oe", 32'(gpio_oe), 32'h00FF);
    tick();
    chk("w_first_bdone", 32'(bus.s_bvalid), 32'd0);
    repeat (3) tick();
    chk("w_first_single", 32'(bus.s_bvalid), 32'd0);
    bus.s_bready = 1'b0;

    // Input sampling, unmapped offsets, read-only register
    gpio_in = 16'h00AA;
    repeat (3) tick();
    do_read("r_din", 32'(OFF_DATA_IN), 32'h0000_00AA, 2'b00);
    do_read("r_unmap14", 32'h14, 32'd0, 2'b10);
    do_write("w_unmap18", 32'h18, 32'hFFFF_FFFF, 4'hF);
    chk("unmap_no_effect", 32'(gpio_out), m_out);
    do_write("w_din", 32'(OFF_DATA_IN), 32'h1234_5678, 4'hF);
    do_write("w_wide", 32'(OFF_DATA_OUT), 32'hFFFF_FFFF, 4'hF);
    do_read("r_wide", 32'(OFF_DATA_OUT), 32'h0000_FFFF, 2'b00);

`ifdef AXIL_GPIO_IRQ_EN
    do_write("w_st_clr", 32'(OFF_IRQ_STATUS), 32'hFFFF_FFFF, 4'hF);
    do_write("w_irq_en", 32'(OFF_IRQ_EN), 32'h0000_0001, 4'hF);
    chk("irq_idle", 32'(irq), 32'd0);
    gpio_in = 16'h00AB;
    repeat (3) tick();
    chk("irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("irq_4edges", 32'(irq), 32'd1);
    do_read("r_status", 32'(OFF_IRQ_STATUS), 32'h0000_0001, 2'b00);
    do_write("w_w1c", 32'(OFF_IRQ_STATUS), 32'h0000_0001, 4'hF);
    chk("irq_at_w1c", 32'(snap_irq), 32'd1);
    chk("irq_cleared", 32'(irq), 32'd0);
    do_read("r_status_clr", 32'(OFF_IRQ_STATUS), 32'd0, 2'b00);
`else
    do_read("r_irq_en_off", 32'(OFF_IRQ_EN), 32'd0, 2'b00);
    do_write("w_irq_en_off", 32'(OFF_IRQ_EN), 32'h0000_0001, 4'hF);
    gpio_in = 16'h00AB;
    repeat (6) tick();
    chk("irq_tied", 32'(irq), 32'd0);
    do_read("r_status_off", 32'(OFF_IRQ_STATUS), 32'd0, 2'b00);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      gpio_in = GW'($urandom);
      idx = 3'($urandom_range(0, 7));
`ifdef AXIL_GPIO_IRQ_EN
      if (idx == 3'd3 || idx == 3'd4) idx = 3'd0;
`endif
      addr = ($urandom & 32'hFFFF_FFE0) | {27'd0, idx, 2'b00} | 32'($urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      do_write("rnd_w", addr, data, strb);
      chk("rnd_out", 32'(gpio_out), m_out);
      chk("rnd_oe", 32'(gpio_oe), m_dir);
      idx = 3'($urandom_range(0, 7));
`ifdef AXIL_GPIO_IRQ_EN
      if (idx == 3'd3 || idx == 3'd4) idx = 3'd2;
`endif
      addr = ($urandom & 32'hFFFF_FFE0) | {27'd0, idx, 2'b00};
      do_read("rnd_r", addr, model_read(addr), model_resp(addr));
    end

    // Same-cycle read and write with both responses back-pressured
    old_out = m_out;
    bus.s_awaddr = 32'(OFF_DATA_OUT); bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h0000_1234; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    bus.s_araddr = 32'(OFF_DATA_OUT); bus.s_arvalid = 1'b1;
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    model_write(32'(OFF_DATA_OUT), 32'h0000_1234, 4'hF);
    chk("bp_out", 32'(gpio_out), m_out);
    for (int c = 0; c < 6; c++) begin
      chk("bp_bvalid", 32'(bus.s_bvalid), 32'd1);
      chk("bp_rvalid", 32'(bus.s_rvalid), 32'd1);
      chk("bp_rdata", bus.s_rdata, old_out);
      chk("bp_awready", 32'(bus.s_awready), 32'd0);
      tick();
    end
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    tick();
    chk("bp_release", 32'({bus.s_bvalid, bus.s_rvalid}), 32'd0);
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;

    // Reset with only the write address accepted
    bus.s_awaddr = 32'(OFF_DIR); bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    chk("half_aw_held", 32'(bus.s_awready), 32'd0);
    areset = 1'b1;
    #1;
    chk("mid_rst_pins", 32'({gpio_out, gpio_oe, irq}), 32'd0);
    chk("mid_rst_bus", 32'({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid}), 32'd0);
    tick();
    areset = 1'b0;
    repeat (2) tick();
    chk("after_rst_ready", 32'(bus.s_awready), 32'd1);
    bus.s_wdata = 32'h0000_00FF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1; bus.s_bready = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    repeat (4) tick();
    chk("no_stale_b", 32'(bus.s_bvalid), 32'd0);
    chk("no_stale_oe", 32'(gpio_oe), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
